img_buf_arbiter: RTL and testbench

- Arbitrates the single-port 256x16 image buffer RAM between two requesters: the Nios PIO port (address/data/wren/interlock PIOs) and the streaming pixel writer.
- Executes Nios single-word reads and writes through a toggle-based interlock.
- Fills frames from the stream with an auto-incrementing pointer.
- Exposes a frame-ready/lock handshake so software can own the buffer between frames.

---
 rtl/img_buf_arbiter.sv | 103 ++++++++++
 tb/tb_img_buf_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_buf_arbiter.sv
// img_buf_arbiter: shares a single-port image buffer RAM between Nios PIO requests and a pixel stream
module img_buf_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 256
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] pio_address,
    input  logic [DATA_W-1:0] pio_data,
    input  logic              pio_wren,
    input  logic [7:0]        pio_interlock,
    output logic [DATA_W-1:0] pio_q,
    output logic [7:0]        pio_status,
    input  logic              strm_valid,
    output logic              strm_ready,
    input  logic [DATA_W-1:0] strm_data,
    input  logic              strm_sof,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              frame_done
);
    typedef enum logic [2:0] {IDLE, PIO_WR, PIO_RD, PIO_CAP, STRM_WR} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);
    state_t state;
    logic [ADDR_W-1:0] wr_ptr;
    logic req_seen, frame_ready, sof_err, ack, lock_d;
    logic lock, pio_pending, grant_slot, last_busy, accept, lock_fall;
    logic unused_interlock;
    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a);
        return a == LAST ? '0 : a + 1'b1;
    endfunction
    assign unused_interlock = ^{pio_interlock[7:3], pio_interlock[1]};
    assign lock = pio_interlock[2];
    assign pio_pending = pio_interlock[0] != req_seen;
    assign grant_slot = state == IDLE || state == STRM_WR;
    // the last word of a frame is being written: hold the stream off until frame_ready takes over
    assign last_busy = state == STRM_WR && ram_address == LAST;
    // lock_d also gates the stream so the pointer clear on lock release never races an accept
    assign strm_ready = reset_reset_n && grant_slot && !pio_pending && !lock && !lock_d && !frame_ready && !last_busy;
    assign accept = strm_valid && strm_ready;
    assign lock_fall = lock_d && !lock;
    assign pio_status = {5'b0, sof_err, frame_ready, ack};
    // arbitration FSM, RAM port registers and frame bookkeeping
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            req_seen    <= 1'b0;
            frame_ready <= 1'b0;
            sof_err     <= 1'b0;
            ack         <= 1'b0;
            lock_d      <= 1'b0;
            pio_q       <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            lock_d     <= lock;
            frame_done <= last_busy;
            ram_wren   <= 1'b0;
            if (lock_fall) begin
                frame_ready <= 1'b0;
                sof_err     <= 1'b0;
                wr_ptr      <= '0;
            end
            if (last_busy)
                frame_ready <= 1'b1;
            case (state)
                PIO_WR: begin
                    state <= IDLE;
                    ack   <= ~ack;
                end
                PIO_RD:
                    state <= PIO_CAP;
                PIO_CAP: begin
                    state <= IDLE;
                    ack   <= ~ack;
                    pio_q <= ram_q;
                end
                default:
                    if (pio_pending) begin
                        req_seen    <= pio_interlock[0];
                        ram_address <= pio_address;
                        ram_data    <= pio_data;
                        ram_wren    <= pio_wren;
                        state       <= pio_wren ? PIO_WR : PIO_RD;
                    end else if (accept) begin
                        ram_address <= strm_sof ? '0 : wr_ptr;
                        ram_data    <= strm_data;
                        ram_wren    <= 1'b1;
                        wr_ptr      <= step(strm_sof ? '0 : wr_ptr);
                        if (strm_sof && wr_ptr != '0)
                            sof_err <= 1'b1;
                        state       <= STRM_WR;
                    end else
                        state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_img_buf_arbiter.sv
// tb_img_buf_arbiter: directed, table-driven and randomised checks of img_buf_arbiter
module tb_img_buf_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] pio_address, pio_interlock, pio_status, ram_address;
    logic [15:0] pio_data, pio_q, strm_data, ram_data, ram_q;
    logic pio_wren, strm_valid, strm_ready, strm_sof, ram_wren, frame_done;
    int checks = 0;
    int errors = 0;
    logic [15:0] mem [256];
    typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
    typedef struct { logic wr; logic [7:0] a; logic [15:0] d; logic [15:0] exp; } vec_t;
    wr_t pq [$];
    wr_t sq [$];
    logic [15:0] shadow [256];
    bit valid_sh [256];
    bit mon_en = 0;
    int m_ptr = 0;
    bit m_frame_ready = 0;
    bit m_sof_err = 0;

    img_buf_arbiter dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .pio_address(pio_address), .pio_data(pio_data), .pio_wren(pio_wren),
        .pio_interlock(pio_interlock), .pio_q(pio_q), .pio_status(pio_status),
        .strm_valid(strm_valid), .strm_ready(strm_ready), .strm_data(strm_data), .strm_sof(strm_sof),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // behavioural single-port RAM with one cycle read latency
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    // scoreboard: every RAM write must be the next expected PIO write or the next expected stream write
    always @(negedge clk)
        if (mon_en && ram_wren) begin
            checks++;
            if (pq.size() > 0 && pq[0].a == ram_address && pq[0].d == ram_data) begin
                shadow[ram_address] = ram_data;
                valid_sh[ram_address] = 1;
                void'(pq.pop_front());
            end else if (sq.size() > 0 && sq[0].a == ram_address && sq[0].d == ram_data) begin
                shadow[ram_address] = ram_data;
                valid_sh[ram_address] = 1;
                void'(sq.pop_front());
            end else begin
                errors++;
                $display("FAIL ram_write: got addr %0h data %0h, expected pio %0h/%0h (n=%0d) or stream %0h/%0h (n=%0d)",
                         ram_address, ram_data,
                         pq.size() > 0 ? pq[0].a : 8'h0, pq.size() > 0 ? pq[0].d : 16'h0, pq.size(),
                         sq.size() > 0 ? sq[0].a : 8'h0, sq.size() > 0 ? sq[0].d : 16'h0, sq.size());
            end
        end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pio_op(input logic wr, input logic [7:0] a, input logic [15:0] d, output logic [15:0] q);
        logic old, ok;
        old = pio_status[0];
        pio_address = a;
        pio_data = d;
        pio_wren = wr;
        pio_interlock[0] = ~pio_interlock[0];
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = pio_status[0] != old;
        end
        chk("pio_ack", 64'(ok), 64'(1));
        q = pio_q;
    endtask

    task automatic lock_pulse();
        pio_interlock[2] = 1'b1;
        repeat (2) @(negedge clk);
        pio_interlock[2] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic stream_chunk(input int n);
        int sent = 0;
        int a;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            strm_valid = sent < n && !m_frame_ready && $urandom_range(0, 3) != 0;
            strm_data = 16'($urandom);
            strm_sof = $urandom_range(0, 31) == 0;
            #1;
            if (strm_valid && strm_ready) begin
                chk("strm_accept_allowed", 64'(m_frame_ready || pio_interlock[2]), 64'(0));
                a = strm_sof ? 0 : m_ptr;
                if (strm_sof && m_ptr != 0) m_sof_err = 1;
                sq.push_back('{8'(a), strm_data});
                if (a == 255) m_frame_ready = 1;
                m_ptr = (a + 1) % 256;
                sent++;
            end
        end
        strm_valid = 1'b0;
        strm_sof = 1'b0;
    endtask

    task automatic pio_chunk(input int n);
        logic [7:0] a;
        logic [15:0] d, q;
        logic wr;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            a = 8'($urandom);
            d = 16'($urandom);
            wr = !valid_sh[a] || $urandom_range(0, 1) == 1;
            if (wr) pq.push_back('{a, d});
            pio_op(wr, a, d, q);
            if (!wr) chk("rand_pio_read", 64'(q), 64'(shadow[a]));
        end
    endtask

    initial begin
        vec_t tbl [12];
        logic [7:0] sof_exp [6];
        logic [15:0] q;
        int bad_rdy, bad_wr, fd;
        bit lk;
        tbl[0]  = '{1'b1, 8'h01, 16'h1111, 16'h0000};
        tbl[1]  = '{1'b1, 8'h02, 16'h2222, 16'h0000};
        tbl[2]  = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000};
        tbl[3]  = '{1'b1, 8'h01, 16'h1357, 16'h0000};
        tbl[4]  = '{1'b0, 8'h01, 16'h0000, 16'h1357};
        tbl[5]  = '{1'b0, 8'h02, 16'h0000, 16'h2222};
        tbl[6]  = '{1'b0, 8'hFF, 16'h0000, 16'hFFFF};
        tbl[7]  = '{1'b1, 8'h00, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b0, 8'h00, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b0, 8'h10, 16'h0000, 16'h0010};
        tbl[10] = '{1'b0, 8'h80, 16'h0000, 16'h0080};
        tbl[11] = '{1'b0, 8'h33, 16'h0000, 16'h1234};
        sof_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        pio_address = 0; pio_data = 0; pio_wren = 0; pio_interlock = 0;
        strm_valid = 0; strm_data = 0; strm_sof = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pio_q, pio_status, strm_ready, ram_address, ram_data, ram_wren, frame_done}, 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(strm_ready), 64'(1));

        // PIO write then read with exact latencies
        pio_address = 8'h10; pio_data = 16'hBEEF; pio_wren = 1; pio_interlock[0] = 1;
        @(negedge clk);
        chk("wr_g1", {ram_wren, ram_address, ram_data, pio_status[0]}, {1'b1, 8'h10, 16'hBEEF, 1'b0});
        @(negedge clk);
        chk("wr_g2", {ram_wren, pio_status[0]}, {1'b0, 1'b1});
        pio_wren = 0; pio_interlock[0] = 0;
        @(negedge clk);
        chk("rd_g1", {ram_wren, ram_address}, {1'b0, 8'h10});
        @(negedge clk);
        chk("rd_g2_ack", 64'(pio_status[0]), 64'(1));
        @(negedge clk);
        chk("rd_g3", {pio_q, pio_status[0]}, {16'hBEEF, 1'b0});

        // full frame fill, back to back
        bad_rdy = 0; bad_wr = 0; fd = 0;
        for (int i = 0; i < 260; i++) begin
            if (i > 0 && i <= 256 && !(ram_wren && ram_address == 8'(i - 1) && ram_data == 16'(i - 1))) bad_wr++;
            if (i > 256 && ram_wren) bad_wr++;
            fd += int'(frame_done);
            strm_valid = i < 256; strm_data = 16'(i); strm_sof = i == 0;
            #1;
            if (strm_valid && !strm_ready) bad_rdy++;
            @(negedge clk);
        end
        chk("fill_ready_bad", 64'(bad_rdy), 64'(0));
        chk("fill_writes_bad", 64'(bad_wr), 64'(0));
        chk("fill_frame_done", 64'(fd), 64'(1));
        chk("fill_frame_ready", 64'(pio_status[1]), 64'(1));
        strm_valid = 1; strm_sof = 0;
        #1 chk("fill_stall", 64'(strm_ready), 64'(0));
        @(negedge clk);
        strm_valid = 0;

        // lock handshake: read back the frame while locked, release restarts at address 0
        pio_interlock[2] = 1;
        pio_op(0, 8'hFF, 16'h0, q);
        chk("lock_read_255", 64'(q), 64'(255));
        chk("lock_frame_ready", 64'(pio_status[1]), 64'(1));
        pio_interlock[2] = 0;
        repeat (2) @(negedge clk);
        chk("unlock_frame_ready", 64'(pio_status[1]), 64'(0));
        strm_valid = 1; strm_data = 16'hAAAA;
        #1 chk("unlock_ready", 64'(strm_ready), 64'(1));
        @(negedge clk);
        chk("unlock_write", {ram_wren, ram_address, ram_data}, {1'b1, 8'h00, 16'hAAAA});
        strm_valid = 0;
        @(negedge clk);

        // collision: PIO wins, stream word follows with the right address
        pio_address = 8'h33; pio_data = 16'h1234; pio_wren = 1; pio_interlock[0] = ~pio_interlock[0];
        strm_valid = 1; strm_data = 16'h5555; strm_sof = 0;
        #1 chk("coll_ready_low", 64'(strm_ready), 64'(0));
        @(negedge clk);
        chk("coll_pio_write", {ram_wren, ram_address, ram_data}, {1'b1, 8'h33, 16'h1234});
        @(negedge clk);
        #1 chk("coll_ready_after", 64'(strm_ready), 64'(1));
        @(negedge clk);
        chk("coll_strm_write", {ram_wren, ram_address, ram_data}, {1'b1, 8'h01, 16'h5555});
        strm_valid = 0;
        lock_pulse();

        // SOF on the 5th word
        for (int i = 0; i < 6; i++) begin
            strm_valid = 1; strm_data = 16'(16'h0A00 + i); strm_sof = i == 4;
            @(negedge clk);
            chk("sof_seq_write", {ram_wren, ram_address, ram_data}, {1'b1, sof_exp[i], 16'(16'h0A00 + i)});
        end
        strm_valid = 0; strm_sof = 0;
        @(negedge clk);
        chk("sof_err_set", 64'(pio_status[2]), 64'(1));
        lock_pulse();
        chk("sof_err_cleared", 64'(pio_status[2]), 64'(0));

        // reset during a stream write
        strm_valid = 1; strm_data = 16'hBBBB;
        @(negedge clk);
        chk("pre_reset_wren", 64'(ram_wren), 64'(1));
        strm_valid = 0; pio_interlock = 0; rst_n = 0;
        #1 chk("reset_mid_outputs", {pio_q, pio_status, strm_ready, ram_address, ram_data, ram_wren, frame_done}, 64'(0));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        strm_valid = 1; strm_data = 16'hCCCC;
        @(negedge clk);
        chk("post_reset_write", {ram_wren, ram_address, ram_data}, {1'b1, 8'h00, 16'hCCCC});
        strm_valid = 0;
        @(negedge clk);

        // table of PIO operations
        for (int i = 0; i < 12; i++) begin
            pio_op(tbl[i].wr, tbl[i].a, tbl[i].d, q);
            if (!tbl[i].wr) chk("tbl_read", {tbl[i].a, q}, {tbl[i].a, tbl[i].exp});
        end

        // randomised mix against the scoreboard and the frame model
        lock_pulse();
        m_ptr = 0; m_frame_ready = 0; m_sof_err = 0;
        mon_en = 1;
        for (int ch = 0; ch < 6; ch++) begin
            lk = $urandom_range(0, 3) == 0;
            pio_interlock[2] = lk;
            fork
                stream_chunk($urandom_range(20, 120));
                pio_chunk($urandom_range(8, 15));
            join
            repeat (5) @(negedge clk);
            chk("rand_pio_queue", 64'(pq.size()), 64'(0));
            chk("rand_strm_queue", 64'(sq.size()), 64'(0));
            chk("rand_status", 64'(pio_status[2:1]), 64'({m_sof_err, m_frame_ready}));
            if (lk || m_frame_ready || $urandom_range(0, 2) == 0) begin
                lock_pulse();
                m_ptr = 0; m_frame_ready = 0; m_sof_err = 0;
                chk("rand_unlock_status", 64'(pio_status[2:1]), 64'(0));
            end
        end
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
